quire_to_posit: RTL and testbench

- Downstream stage of the segmented posit accumulator.
- Captures the accumulator's five carry-pending segments once the accumulator asserts acc_rdy, resolves all carries into one two's-complement quire, then normalises and rounds it to a WIDTH-bit posit (ES=EXP).
- Delivers the result on a valid/ready handshake to the output/writeback stage.

---
 rtl/posit_pkg.sv | 45 ++++
 rtl/quire_to_posit_if.sv | 51 +++++
 rtl/quire_lzd.sv | 30 +++
 rtl/quire_to_posit.sv | 203 ++++++++++++++++++++
 tb/tb_quire_to_posit.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : posit_pkg                                                  |
// | Brief   : Shared widths, FSM state encoding and posit limit values   |
// |           for the quire-to-posit conversion stage.                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package posit_pkg;

  // Value bits carried by one body segment of the accumulator.
  function automatic int acc_w(input int width, input int exp);
    return (2 ** exp) * (width - 2);
  endfunction

  // Head segment width: room for K products plus sign.
  function automatic int head_w(input int k);
    return $clog2(k) + 2;
  endfunction

  // Largest positive posit magnitude for a given width (0x7F.. pattern).
  function automatic logic [63:0] maxpos_f(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Default derived widths (WIDTH=8, K=9, EXP=2).
  localparam int ACC      = acc_w(8, 2);
  localparam int ACC_HEAD = head_w(9);
  localparam int QW       = ACC_HEAD + 4 * ACC;
  localparam int FRAC     = 2 * ACC;

  // Default posit limits for WIDTH=8.
  localparam logic [7:0] MAXPOS = 8'h7F;
  localparam logic [7:0] MINPOS = 8'h01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESOLVE = 3'd1,
    ABS     = 3'd2,
    NORM    = 3'd3,
    ROUND   = 3'd4,
    OUT     = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/quire_to_posit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : quire_to_posit_if                                        |
// | Brief     : Accumulator segment capture and posit result handshake.  |
// |             Optional clamp_o wire when QUIRE_CLAMP_FLAG_EN is set.    |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface quire_to_posit_if
  import posit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 9,
  parameter int EXP   = 2
);
  localparam int SEG_W  = acc_w(WIDTH, EXP);
  localparam int HEAD_W = head_w(K);

  logic                acc_rdy;
  logic [HEAD_W-1:0]   acc_100_c;
  logic [SEG_W+1:0]    acc_000_c;
  logic [SEG_W+1:0]    acc_001_c;
  logic [SEG_W+1:0]    acc_010_c;
  logic [SEG_W+1:0]    acc_011_c;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    posit_o;
  logic                busy_o;
  logic                ovr_o;
`ifdef QUIRE_CLAMP_FLAG_EN
  logic                clamp_o;

  modport slave (
    input  acc_rdy, acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c, out_ready,
    output out_valid, posit_o, busy_o, ovr_o, clamp_o
  );
  modport master (
    output acc_rdy, acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c, out_ready,
    input  out_valid, posit_o, busy_o, ovr_o, clamp_o
  );
`else
  modport slave (
    input  acc_rdy, acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c, out_ready,
    output out_valid, posit_o, busy_o, ovr_o
  );
  modport master (
    output acc_rdy, acc_100_c, acc_000_c, acc_001_c, acc_010_c, acc_011_c, out_ready,
    input  out_valid, posit_o, busy_o, ovr_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/quire_lzd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : quire_lzd                                                   |
// | Brief  : Leading-one detector; returns the index of the highest set  |
// |          bit and whether any bit is set.                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module quire_lzd #(
  parameter int W  = 102,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  din,
  output logic [PW-1:0] pos,
  output logic          found
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        pos   = PW'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/quire_to_posit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : quire_to_posit                                              |
// | Brief  : Resolves the carry-pending quire segments, then normalises  |
// |          and rounds (nearest, ties to even) to a WIDTH-bit posit.    |
// |          Define QUIRE_CLAMP_FLAG_EN to add the clamp_o flag.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module quire_to_posit
  import posit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 9,
  parameter int EXP   = 2
) (
  input  logic              clk_i,
  input  logic              rst,
  quire_to_posit_if.slave   bus
);
  localparam int ACC      = acc_w(WIDTH, EXP);
  localparam int ACC_HEAD = head_w(K);
  localparam int QW       = ACC_HEAD + 4 * ACC;
  localparam int FRAC     = 2 * ACC;
  localparam int PW       = $clog2(QW);
  localparam int SW       = PW + 2;
  // regime(2) + e + fraction + guard + padding wide enough for the longest unclamped regime
  localparam int T        = 2 * WIDTH + EXP + 3;

  localparam logic [WIDTH-1:0] MAXPOS_W = WIDTH'(maxpos_f(WIDTH));
  localparam logic [WIDTH-1:0] MINPOS_W = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_RESOLVE = 3'(RESOLVE);
  localparam logic [2:0] S_ABS     = 3'(ABS);
  localparam logic [2:0] S_NORM    = 3'(NORM);
  localparam logic [2:0] S_ROUND   = 3'(ROUND);
  localparam logic [2:0] S_OUT     = 3'(OUT);

  logic [2:0]            state;
  logic                  rdy_q;
  logic                  cap_edge;
  logic [ACC_HEAD-1:0]   seg_100;
  logic [ACC+1:0]        seg_000, seg_001, seg_010, seg_011;
  logic [QW-1:0]         q, q_sum, mag, shifted;
  logic                  sign, zero, guard, sticky;
  logic [WIDTH-1:0]      frac;
  logic signed [SW-1:0]  scale;
  logic [PW-1:0]         lead_pos;
  logic                  lead_found;
  logic                  out_valid_r, ovr_r;
  logic [WIDTH-1:0]      posit_r;

  // rounding datapath
  int                    k_i;
  logic [EXP-1:0]        e_w;
  logic [T-1:0]          v0, v;
  logic [WIDTH-2:0]      body, body_r;
  logic                  rb, st, sat_hi, sat_lo, clamp_w;
  logic [WIDTH-1:0]      mag_p, res;

  assign cap_edge = bus.acc_rdy & ~rdy_q;

  assign bus.out_valid = out_valid_r;
  assign bus.posit_o   = posit_r;
  assign bus.busy_o    = (state != S_IDLE);
  assign bus.ovr_o     = ovr_r;

  // Every segment is unsigned; pending carries add in naturally, wrap mod 2^QW.
  assign q_sum = (QW'(seg_100) << (4 * ACC)) + (QW'(seg_000) << (3 * ACC))
               + (QW'(seg_001) << (2 * ACC)) + (QW'(seg_010) << ACC)
               + QW'(seg_011);

  quire_lzd #(.W(QW), .PW(PW)) u_lzd (
    .din   (mag),
    .pos   (lead_pos),
    .found (lead_found)
  );

  // Leading one moved to the MSB; bits below it are fraction, guard, sticky.
  assign shifted = mag << (PW'(QW - 1) - lead_pos);

  // Posit encoding: regime built by shifting a 10/01 seed so the run length follows k.
  always_comb begin
    k_i    = int'(scale) >>> EXP;
    e_w    = scale[EXP-1:0];
    sat_hi = (k_i >= WIDTH - 2);
    sat_lo = (k_i <= -(WIDTH - 1));
    if (k_i >= 0) begin
      v0 = {2'b10, e_w, frac, guard, {WIDTH{1'b0}}};
      v  = $signed(v0) >>> k_i;
    end else begin
      v0 = {2'b01, e_w, frac, guard, {WIDTH{1'b0}}};
      v  = v0 >> (-k_i - 1);
    end
    body    = v[T-1 -: WIDTH-1];
    rb      = v[T-WIDTH];
    st      = (|v[T-WIDTH-1:0]) | sticky;
    body_r  = body + (WIDTH-1)'(rb & (body[0] | st));
    clamp_w = (k_i > WIDTH - 2) || sat_lo ||
              ((k_i == WIDTH - 2) && ((|e_w) || (|frac) || guard || sticky));
    if (sat_hi)      mag_p = MAXPOS_W;
    else if (sat_lo) mag_p = MINPOS_W;
    else             mag_p = {1'b0, body_r};
    if (zero) begin
      res     = '0;
      clamp_w = 1'b0;
    end else begin
      res     = sign ? -mag_p : mag_p;
    end
  end

  // acc_rdy edge history and sticky overrun flag.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      rdy_q <= bus.acc_rdy;
      if (cap_edge && state != S_IDLE) ovr_r <= 1'b1;
    end
  end

  // Control sequence and output handshake.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid_r <= 1'b0;
      posit_r     <= '0;
    end else begin
      case (state)
        S_IDLE:    if (cap_edge) state <= S_RESOLVE;
        S_RESOLVE: state <= S_ABS;
        S_ABS:     state <= S_NORM;
        S_NORM:    state <= S_ROUND;
        S_ROUND: begin
          state       <= S_OUT;
          out_valid_r <= 1'b1;
          posit_r     <= res;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Datapath pipeline registers, each loaded in its own state.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      seg_100 <= '0;
      seg_000 <= '0;
      seg_001 <= '0;
      seg_010 <= '0;
      seg_011 <= '0;
      q       <= '0;
      mag     <= '0;
      sign    <= 1'b0;
      zero    <= 1'b0;
      frac    <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      scale   <= '0;
    end else begin
      if (state == S_IDLE && cap_edge) begin
        seg_100 <= bus.acc_100_c;
        seg_000 <= bus.acc_000_c;
        seg_001 <= bus.acc_001_c;
        seg_010 <= bus.acc_010_c;
        seg_011 <= bus.acc_011_c;
      end
      if (state == S_RESOLVE) q <= q_sum;
      if (state == S_ABS) begin
        // The most negative quire negates to itself; its magnitude saturates later.
        sign <= q[QW-1];
        mag  <= q[QW-1] ? -q : q;
      end
      if (state == S_NORM) begin
        zero   <= ~lead_found;
        frac   <= shifted[QW-2 -: WIDTH];
        guard  <= shifted[QW-2-WIDTH];
        sticky <= |shifted[QW-3-WIDTH:0];
        scale  <= $signed({2'b00, lead_pos}) - $signed(SW'(FRAC));
      end
    end
  end

`ifdef QUIRE_CLAMP_FLAG_EN
  logic clamp_r;
  assign bus.clamp_o = clamp_r;

  // Clamp indication travels with the result it describes.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst)                  clamp_r <= 1'b0;
    else if (state == S_ROUND) clamp_r <= clamp_w;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_quire_to_posit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_quire_to_posit                                           |
// | Brief  : Scoreboard bench for quire_to_posit (WIDTH=8, EXP=2).        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_quire_to_posit;

  typedef struct packed {
    logic [7:0] posit;
    logic       clamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  quire_to_posit_if #(.WIDTH(8), .K(9), .EXP(2)) bus ();

  quire_to_posit #(.WIDTH(8), .K(9), .EXP(2)) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h, expected none", bus.posit_o);
      end else begin
        mon_e = sb.pop_front();
        check("posit", {24'd0, bus.posit_o}, {24'd0, mon_e.posit});
`ifdef QUIRE_CLAMP_FLAG_EN
        check("clamp", {31'd0, bus.clamp_o}, {31'd0, mon_e.clamp});
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.busy_o && n < 100);
    if (bus.busy_o) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic load(input logic [5:0] h, input logic [25:0] a, b, c, d);
    bus.acc_100_c = h;
    bus.acc_000_c = a;
    bus.acc_001_c = b;
    bus.acc_010_c = c;
    bus.acc_011_c = d;
    bus.acc_rdy   = 1'b1;
  endtask

  task automatic run_vec(input string name, input logic [5:0] h, input logic [25:0] a, b, c, d,
                         input logic [7:0] ex, input logic cl);
    int n;
    wait_idle();
    load(h, a, b, c, d);
    sb.push_back('{posit: ex, clamp: cl});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 20);
    check({name, "_latency"}, n, 32'd5);
    n = 0;
    while (bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.out_valid) check({name, "_accept_timeout"}, 32'd1, 32'd0);
    bus.acc_rdy = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.acc_rdy = 1'b0;
    bus.out_ready = 1'b1;
    load(6'h0, 26'h0, 26'h0, 26'h0, 26'h0);
    bus.acc_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_posit",     {24'd0, bus.posit_o},   32'd0);
    check("rst_busy",      {31'd0, bus.busy_o},    32'd0);
    check("rst_ovr",       {31'd0, bus.ovr_o},     32'd0);
    rst = 1'b0;

    run_vec("one",       6'h00, 26'h0,      26'h1,      26'h0,       26'h0, 8'h40, 1'b0);
    run_vec("minus_one", 6'h3F, 26'hFFFFFF, 26'hFFFFFF, 26'h0,       26'h0, 8'hC0, 1'b0);
    run_vec("carry_one", 6'h00, 26'h0,      26'h0,      26'h1000000, 26'h0, 8'h40, 1'b0);
    run_vec("tie_down",  6'h00, 26'h0,      26'h1,      26'h100000,  26'h0, 8'h40, 1'b0);
    run_vec("tie_up",    6'h00, 26'h0,      26'h1,      26'h300000,  26'h0, 8'h42, 1'b0);
    run_vec("maxpos",    6'h01, 26'h0,      26'h0,      26'h0,       26'h0, 8'h7F, 1'b1);
    run_vec("minpos",    6'h00, 26'h0,      26'h0,      26'h0,       26'h1, 8'h01, 1'b1);
    run_vec("zero",      6'h00, 26'h0,      26'h0,      26'h0,       26'h0, 8'h00, 1'b0);
    run_vec("two",       6'h00, 26'h0,      26'h2,      26'h0,       26'h0, 8'h48, 1'b0);
    run_vec("half",      6'h00, 26'h0,      26'h0,      26'h800000,  26'h0, 8'h38, 1'b0);
    run_vec("most_neg",  6'h20, 26'h0,      26'h0,      26'h0,       26'h0, 8'h81, 1'b1);

    // Back-pressure: result must hold; a second capture edge only raises ovr_o.
    bus.out_ready = 1'b0;
    wait_idle();
    load(6'h00, 26'h0, 26'h1, 26'h0, 26'h0);
    sb.push_back('{posit: 8'h40, clamp: 1'b0});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 20);
    check("hold_latency", n, 32'd5);
    check("hold_ovr_before", {31'd0, bus.ovr_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) bus.acc_rdy = 1'b0;
      if (i == 4) bus.acc_rdy = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_posit", {24'd0, bus.posit_o}, 32'h40);
    end
    check("hold_ovr_after", {31'd0, bus.ovr_o}, 32'd1);
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("hold_released", {31'd0, bus.out_valid}, 32'd0);
    bus.acc_rdy = 1'b0;

    // Reset while in NORM discards the in-flight result.
    wait_idle();
    load(6'h00, 26'h0, 26'h2, 26'h0, 26'h0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    bus.acc_rdy = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy",  {31'd0, bus.busy_o},    32'd0);
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_ovr",   {31'd0, bus.ovr_o},     32'd0);
    rst = 1'b0;
    run_vec("after_rst", 6'h00, 26'h0, 26'h0, 26'h800000, 26'h0, 8'h38, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
